// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the instruction issue queue: NOP encoding,
// default instruction width and the queue occupancy states.
package cpu_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_e;

endpackage

// File: rtl/instr_queue_mem.sv
// DEPTH x XLEN instruction storage: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module instr_queue_mem #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [DEPTH];

    // Write port: store the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue feeding a registered instr/instr_valid pair to the CPU.
// Optional empty-queue bypass (1-edge latency) is enabled by INSTR_QUEUE_BYPASS_EN.
module instr_issue_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = XLEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       in_ready,
    input  logic                       hold,
    input  logic                       flush,
    output logic [XLEN-1:0]            instr,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                issued_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP_INSTR);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    occ_state_e      state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d, head_s;
    logic            valid_q, valid_d;
    logic [31:0]     issued_q, issued_d;
    logic            in_ready_s, push_s, pop_s, bypass_s, store_s, we_s;

    // Handshake decode: push, pop and (optionally) the empty-queue bypass.
    always_comb begin
        in_ready_s = (state_q != OCC_FULL);
        pop_s      = !hold && !flush && (state_q != OCC_EMPTY);
        push_s     = in_valid && in_ready_s && !flush;
`ifdef INSTR_QUEUE_BYPASS_EN
        bypass_s   = push_s && !hold && (state_q == OCC_EMPTY);
`else
        bypass_s   = 1'b0;
`endif
        store_s    = push_s && !bypass_s;
        we_s       = store_s && !rst;
    end

    instr_queue_mem #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_q),
        .wdata (in_instr),
        .raddr (rd_ptr_q),
        .rdata (head_s)
    );

    // Pointer, occupancy count and occupancy FSM next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
            state_d  = OCC_EMPTY;
        end else begin
            if (store_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({store_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                OCC_EMPTY: begin
                    if (store_s && !pop_s) begin
                        state_d = OCC_PARTIAL;
                    end else begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_PARTIAL: begin
                    if (store_s && !pop_s && (count_q == CW'(DEPTH - 1))) begin
                        state_d = OCC_FULL;
                    end else if (pop_s && !store_s && (count_q == CW'(1))) begin
                        state_d = OCC_EMPTY;
                    end else begin
                        state_d = OCC_PARTIAL;
                    end
                end
                OCC_FULL: begin
                    if (pop_s && !store_s) begin
                        state_d = OCC_PARTIAL;
                    end else begin
                        state_d = OCC_FULL;
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    // Issue register: flush beats hold; idle cycles present NOP as filler.
    always_comb begin
        instr_d  = instr_q;
        valid_d  = valid_q;
        issued_d = issued_q;
        if (flush) begin
            instr_d = NOP_W;
            valid_d = 1'b0;
        end else if (hold) begin
            instr_d = instr_q;
            valid_d = valid_q;
        end else if (pop_s) begin
            instr_d  = head_s;
            valid_d  = 1'b1;
            issued_d = issued_q + 32'd1;
        end else if (bypass_s) begin
            instr_d  = in_instr;
            valid_d  = 1'b1;
            issued_d = issued_q + 32'd1;
        end else begin
            instr_d = NOP_W;
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            state_q  <= OCC_EMPTY;
            instr_q  <= NOP_W;
            valid_q  <= 1'b0;
            issued_q <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            issued_q <= issued_d;
        end
    end

    assign in_ready    = in_ready_s;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign count       = count_q;
    assign issued_cnt  = issued_q;

endmodule
